uart_rx_fifo: RTL and testbench

- Downstream consumer of the UART receiver's byte-ready handshake (rdy/dout/rdy_clr).
- Drains each received byte into a DEPTH-entry first-word-fall-through FIFO and acknowledges it via a one-cycle rdy_clr pulse.
- Presents bytes to the host on a valid/ready stream interface.
- Reports fill level, an almost-full flag and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 tb/tb_uart_rx_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver, transmitter and rx FIFO:
// the byte width and the rx capture FSM encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_HOLD = 1'b1
    } cap_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is always visible on o_data.
// The occupancy count is held separately from the pointers, so full and empty are never ambiguous.
module uart_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_push_acc,
    output logic [W-1:0]  o_data,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_do_pop   = i_pop & (r_count != '0);
    assign w_do_push  = i_push & ((r_count != FULL_CNT) | w_do_pop);
    assign o_push_acc = w_do_push;
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains the UART receiver's byte-ready handshake into a FWFT FIFO and serves the
// bytes to the host as a valid/ready stream, with fill level and overflow status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int AFULL_LVL = 12,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_rx_rdy,
    input  logic [UART_DATA_W-1:0] i_rx_dout,
    output logic                   o_rx_rdy_clr,
    output logic [UART_DATA_W-1:0] o_m_data,
    output logic                   o_m_valid,
    input  logic                   i_m_ready,
    input  logic                   i_flush,
    input  logic                   i_ovf_clr,
    output logic [AW:0]            o_count,
    output logic                   o_almost_full,
    output logic                   o_overflow,
    output cap_state_t             o_cap_state
);

    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

    cap_state_t r_state;
    cap_state_t w_state_nxt;
    logic       w_capture;
    logic       r_rx_rdy_clr;
    logic       r_overflow;
    logic       w_pop;
    logic       w_push_acc;
    logic       w_drop;
    logic [AW:0] w_count;

    // Capture FSM. HOLD masks rx_rdy for the one cycle the receiver needs to see
    // the registered clear; rx_rdy still high afterwards is a new byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= CAP_IDLE;
            r_rx_rdy_clr <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_rdy_clr <= w_capture;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            CAP_IDLE: begin
                if (i_rx_rdy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = CAP_HOLD;
                end
            end
            CAP_HOLD: w_state_nxt = CAP_IDLE;
        endcase
    end

    // Host stream: a byte transfers on every clock edge where o_m_valid and i_m_ready
    // are both high; o_m_data is stable while o_m_valid waits for i_m_ready.
    assign w_pop  = o_m_valid & i_m_ready;
    assign w_drop = w_capture & ~w_push_acc & ~i_flush;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_capture),
        .i_data     (i_rx_dout),
        .i_pop      (w_pop),
        .i_flush    (i_flush),
        .o_push_acc (w_push_acc),
        .o_data     (o_m_data),
        .o_count    (w_count)
    );

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_rx_rdy_clr  = r_rx_rdy_clr;
    assign o_m_valid     = (w_count != '0);
    assign o_count       = w_count;
    assign o_almost_full = (w_count >= AFULL_CNT);
    assign o_overflow    = r_overflow;
    assign o_cap_state   = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a receiver-side driver, a queue-level reference model that
// predicts bytes and status, and a monitor that compares the DUT against those predictions.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       rx_rdy, rx_rdy_clr, m_valid, m_ready, flush, ovf_clr;
    logic       almost_full, overflow;
    logic [7:0] rx_dout, m_data;
    logic [4:0] count;
    cap_state_t cap_state;

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_rx_rdy      (rx_rdy),
        .i_rx_dout     (rx_dout),
        .o_rx_rdy_clr  (rx_rdy_clr),
        .o_m_data      (m_data),
        .o_m_valid     (m_valid),
        .i_m_ready     (m_ready),
        .i_flush       (flush),
        .i_ovf_clr     (ovf_clr),
        .o_count       (count),
        .o_almost_full (almost_full),
        .o_overflow    (overflow),
        .o_cap_state   (cap_state)
    );

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [4:0] cnt;
        logic       ovf;
        logic       clr;
    } sts_t;

    logic [7:0] exp_q[$];
    sts_t       sts_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_tmo = 0;
    bit         done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Predicts, for every clock edge, what the FIFO holds afterwards.
    int  mdl_cnt = 0;
    bit  mdl_ovf = 1'b0;
    bit  mdl_ack = 1'b0;
    bit  m_cap, m_pop, m_drop;
    sts_t m_s;

    always @(negedge clk) begin
        #1;
        if (reset) begin
            mdl_cnt = 0;
            mdl_ovf = 1'b0;
            mdl_ack = 1'b0;
            exp_q.delete();
        end else begin
            m_cap  = rx_rdy && !mdl_ack;
            m_pop  = (mdl_cnt > 0) && m_ready;
            m_drop = 1'b0;
            if (flush) begin
                mdl_cnt = 0;
                exp_q.delete();
            end else begin
                if (m_pop) mdl_cnt--;
                if (m_cap) begin
                    if (mdl_cnt < DEPTH) begin
                        exp_q.push_back(rx_dout);
                        mdl_cnt++;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end
            if (m_drop) mdl_ovf = 1'b1;
            else if (ovf_clr) mdl_ovf = 1'b0;
            mdl_ack = m_cap;
        end
        m_s.cnt = 5'(mdl_cnt);
        m_s.ovf = mdl_ovf;
        m_s.clr = mdl_ack;
        sts_q.push_back(m_s);
    end

    // ---------------- monitor ----------------
    sts_t mon_s;

    always @(negedge clk) begin
        if (reset) begin
            if (sts_q.size() > 0) mon_s = sts_q.pop_front();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", 32'(m_data), 32'd0);
            chk("rst_rdy_clr", 32'(rx_rdy_clr), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_almost_full", 32'(almost_full), 32'd0);
            chk("rst_cap_state", 32'(cap_state), 32'(CAP_IDLE));
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
                else chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (sts_q.size() > 0) begin
                mon_s = sts_q.pop_front();
                chk("count", 32'(count), 32'(mon_s.cnt));
                chk("m_valid", 32'(m_valid), 32'(mon_s.cnt != 5'd0));
                chk("almost_full", 32'(almost_full), 32'(mon_s.cnt >= 5'(AFULL)));
                chk("overflow", 32'(overflow), 32'(mon_s.ovf));
                chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(mon_s.clr));
            end
        end
        if (done) begin
            chk("bytes_left", 32'(exp_q.size()), 32'd0);
            chk("timeouts", 32'(n_tmo), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] nxt_q[$];
    bit clr_pend = 1'b0;
    bit rand_mode = 1'b0;
    bit b2b = 1'b0;
    int rdy_pct = 50;

    // One clock of receiver behaviour: rdy is dropped (or reloaded) on the edge
    // after the acknowledge was seen, mimicking the receiver's registered clear.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            m_ready = ($urandom_range(99) < rdy_pct);
            flush   = ($urandom_range(63) == 0);
            ovf_clr = ($urandom_range(31) == 0);
            b2b     = ($urandom_range(1) == 1);
            if (nxt_q.size() == 0) nxt_q.push_back(8'($urandom));
        end
        if (clr_pend) begin
            clr_pend = 1'b0;
            rx_rdy   = 1'b0;
            if (b2b && nxt_q.size() > 0) begin
                rx_dout = nxt_q.pop_front();
                rx_rdy  = 1'b1;
            end
        end else if (!rx_rdy && nxt_q.size() > 0 && (!rand_mode || $urandom_range(3) == 0)) begin
            rx_dout = nxt_q.pop_front();
            rx_rdy  = 1'b1;
        end
        if (rx_rdy_clr) clr_pend = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((nxt_q.size() > 0 || rx_rdy || clr_pend) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) begin
            n_tmo++;
            $display("timeout: receiver never went idle at %0t", $time);
        end
    endtask

    task automatic drain();
        int k = 0;
        m_ready = 1'b1;
        while (m_valid && k < 200) begin
            step();
            k++;
        end
        m_ready = 1'b0;
        if (k >= 200) begin
            n_tmo++;
            $display("timeout: FIFO never emptied at %0t", $time);
        end
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; rx_rdy = 1'b0; rx_dout = 8'h00;
        m_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        nxt_q.push_back(8'hA5);
        wait_idle();
        drain();

        for (int i = 1; i <= 16; i++) nxt_q.push_back(8'(i));
        wait_idle();

        nxt_q.push_back(8'h77);
        wait_idle();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;

        nxt_q.push_back(8'h55);
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
        drain();

        b2b = 1'b1;
        nxt_q.push_back(8'h3C);
        nxt_q.push_back(8'hC3);
        wait_idle();
        b2b = 1'b0;

        nxt_q.push_back(8'h11);
        nxt_q.push_back(8'h22);
        wait_idle();
        nxt_q.push_back(8'hEE);
        step();
        step();
        #1 reset = 1'b1;
        clr_pend = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_idle();

        nxt_q.push_back(8'h99);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle();
        drain();

        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rdy_pct = ((c / 400) % 2 == 1) ? 85 : 15;
            step();
        end
        rand_mode = 1'b0;
        flush = 1'b0;
        ovf_clr = 1'b0;
        b2b = 1'b0;
        nxt_q.delete();
        wait_idle();
        drain();
        repeat (3) step();
        done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
